// File: rtl/board_mem.sv
// board_mem: 10x20 Tetris occupancy store with probe/VGA read ports,
// a single-cell write port and a line-clear engine that removes full rows.
module board_mem #(
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [3:0] board_rx,
    input  logic [4:0] board_ry,
    output logic       board_rdata,
    input  logic       board_we,
    input  logic [3:0] board_wx,
    input  logic [4:0] board_wy,
    input  logic       board_wdata,
    input  logic [3:0] vga_rx,
    input  logic [4:0] vga_ry,
    output logic       vga_rdata,
    input  logic       clear_start,
    output logic       clear_busy,
    output logic       clear_done,
    output logic [4:0] lines_cleared
);

    localparam logic [3:0] COLS_L = 4'(COLS);
    localparam logic [4:0] ROWS_L = 5'(ROWS);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

    typedef struct packed {
        logic       we;
        logic [3:0] x;
        logic [4:0] y;
        logic       d;
    } wr_req_t;

    logic [COLS-1:0] rows_q [ROWS];
    state_t          state, state_nxt;
    logic [4:0]      scan_row;
    logic [4:0]      counter;
    logic [4:0]      lines_q;
    wr_req_t         wr;
    logic            wr_ok;
    logic            row_full;
    logic            in_full;
    logic [COLS-1:0] in_row;

    assign wr    = '{we: board_we, x: board_wx, y: board_wy, d: board_wdata};
    assign wr_ok = wr.we && (state == IDLE) && (wr.x < COLS_L) && (wr.y < ROWS_L);

    // Probe port: walls/floor read as occupied so collision checks need no bounds logic
    always_comb begin
        board_rdata = 1'b1;
        if ((board_rx < COLS_L) && (board_ry < ROWS_L))
            board_rdata = rows_q[board_ry][board_rx];
    end

    // Renderer port: off-board reads as empty
    always_comb begin
        vga_rdata = 1'b0;
        if ((vga_rx < COLS_L) && (vga_ry < ROWS_L))
            vga_rdata = rows_q[vga_ry][vga_rx];
    end

    // Row under test and the row that a shift drops into scan_row
    always_comb begin
        row_full = &rows_q[scan_row];
        in_row   = '0;
        if (scan_row != 5'd0)
            in_row = rows_q[scan_row - 5'd1];
        in_full  = &in_row;
    end

    // The SHIFT cycle also judges the row it is pulling into scan_row, so a full
    // row arriving keeps shifting without spending a separate SCAN cycle on it
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clear_start) state_nxt = SCAN;
            SCAN: begin
                if (row_full)              state_nxt = SHIFT;
                else if (scan_row == 5'd0) state_nxt = DONE;
            end
            SHIFT: begin
                if (in_full)               state_nxt = SHIFT;
                else if (scan_row == 5'd0) state_nxt = DONE;
                else                       state_nxt = SCAN;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Scan pointer, cleared-row counter and the held result
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            scan_row <= LAST_ROW;
            counter  <= 5'd0;
            lines_q  <= 5'd0;
        end else begin
            case (state)
                IDLE: if (clear_start) begin
                    scan_row <= LAST_ROW;
                    counter  <= 5'd0;
                end
                SCAN:  if (!row_full && scan_row != 5'd0) scan_row <= scan_row - 5'd1;
                SHIFT: begin
                    counter <= counter + 5'd1;
                    if (!in_full && scan_row != 5'd0) scan_row <= scan_row - 5'd1;
                end
                DONE:  lines_q <= counter;
                default: ;
            endcase
        end
    end

    // Cell storage: single-cell writes in IDLE, whole-board shift during a clear
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < ROWS; k++) rows_q[k] <= '0;
        end else if (state == SHIFT) begin
            for (int k = 1; k < ROWS; k++)
                if (5'(k) <= scan_row) rows_q[k] <= rows_q[k-1];
            rows_q[0] <= '0;
        end else if (wr_ok) begin
            rows_q[wr.y][wr.x] <= wr.d;
        end
    end

    assign clear_busy    = (state != IDLE);
    assign clear_done    = (state == DONE);
    assign lines_cleared = (state == DONE) ? counter : lines_q;

endmodule

// File: tb/tb_board_mem.sv
// tb_board_mem: directed scenarios for board_mem, one task per feature.
module tb_board_mem;
    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int NC   = COLS * ROWS;

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic [3:0] board_rx, board_wx, vga_rx;
    logic [4:0] board_ry, board_wy, vga_ry;
    logic       board_rdata, board_we, board_wdata, vga_rdata;
    logic       clear_start, clear_busy, clear_done;
    logic [4:0] lines_cleared;

    int n_cmp  = 0;
    int n_fail = 0;

    board_mem #(.COLS(COLS), .ROWS(ROWS)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn),
        .board_rx(board_rx), .board_ry(board_ry), .board_rdata(board_rdata),
        .board_we(board_we), .board_wx(board_wx), .board_wy(board_wy),
        .board_wdata(board_wdata),
        .vga_rx(vga_rx), .vga_ry(vga_ry), .vga_rdata(vga_rdata),
        .clear_start(clear_start), .clear_busy(clear_busy),
        .clear_done(clear_done), .lines_cleared(lines_cleared)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        #3;
        resetn = 1'b1;
        tick();
    endtask

    task automatic wr(input int x, input int y, input logic d);
        board_we = 1'b1; board_wx = 4'(x); board_wy = 5'(y); board_wdata = d;
        tick();
        board_we = 1'b0;
    endtask

    task automatic fill_row(input int y);
        for (int x = 0; x < COLS; x++) wr(x, y, 1'b1);
    endtask

    task automatic read_board(output logic [NC-1:0] pb, output logic [NC-1:0] vb);
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) begin
                board_rx = 4'(x); board_ry = 5'(y); vga_rx = 4'(x); vga_ry = 5'(y);
                #1;
                pb[y*COLS+x] = board_rdata;
                vb[y*COLS+x] = vga_rdata;
            end
    endtask

    // Pulses clear_start in cycle 0; optionally injects a write and a restart in cycle 5
    task automatic run_clear(input bit inject, output int done_cyc, output int busy_cyc,
                             output logic [4:0] lc, output logic busy_after);
        done_cyc = -1; busy_cyc = 0; lc = 5'd0;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int c = 1; c <= 100 && done_cyc < 0; c++) begin
            if (inject && c == 5) begin
                board_we = 1'b1; board_wx = 4'd0; board_wy = 5'd0; board_wdata = 1'b1;
                clear_start = 1'b1;
            end
            if (clear_busy) busy_cyc++;
            if (clear_done) begin done_cyc = c; lc = lines_cleared; end
            tick();
            board_we = 1'b0; clear_start = 1'b0;
        end
        busy_after = clear_busy;
    endtask

    task automatic test_reset;
        logic [NC-1:0] pb, vb;
        read_board(pb, vb);
        n_cmp++; if (pb !== '0) begin n_fail++; $display("FAIL reset_probe: got %h want 0", pb); end
        n_cmp++; if (vb !== '0) begin n_fail++; $display("FAIL reset_vga: got %h want 0", vb); end
        board_rx = 4'd10; board_ry = 5'd0; vga_rx = 4'd10; vga_ry = 5'd0; #1;
        n_cmp++; if (board_rdata !== 1'b1) begin n_fail++; $display("FAIL probe_10_0: got %b want 1", board_rdata); end
        n_cmp++; if (vga_rdata !== 1'b0) begin n_fail++; $display("FAIL vga_10_0: got %b want 0", vga_rdata); end
        board_rx = 4'd0; board_ry = 5'd20; vga_rx = 4'd0; vga_ry = 5'd20; #1;
        n_cmp++; if (board_rdata !== 1'b1) begin n_fail++; $display("FAIL probe_0_20: got %b want 1", board_rdata); end
        n_cmp++; if (vga_rdata !== 1'b0) begin n_fail++; $display("FAIL vga_0_20: got %b want 0", vga_rdata); end
        board_rx = 4'd15; board_ry = 5'd31; vga_rx = 4'd15; vga_ry = 5'd31; #1;
        n_cmp++; if (board_rdata !== 1'b1) begin n_fail++; $display("FAIL probe_15_31: got %b want 1", board_rdata); end
        n_cmp++; if (vga_rdata !== 1'b0) begin n_fail++; $display("FAIL vga_15_31: got %b want 0", vga_rdata); end
        n_cmp++; if (lines_cleared !== 5'd0) begin n_fail++; $display("FAIL reset_lines: got %0d want 0", lines_cleared); end
        n_cmp++; if (clear_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", clear_busy); end
        n_cmp++; if (clear_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", clear_done); end
    endtask

    task automatic test_write;
        logic [NC-1:0] pb, vb, e;
        wr(3, 7, 1'b1);
        board_rx = 4'd3; board_ry = 5'd7; vga_rx = 4'd3; vga_ry = 5'd7; #1;
        n_cmp++; if (board_rdata !== 1'b1) begin n_fail++; $display("FAIL wr_probe_3_7: got %b want 1", board_rdata); end
        n_cmp++; if (vga_rdata !== 1'b1) begin n_fail++; $display("FAIL wr_vga_3_7: got %b want 1", vga_rdata); end
        e = '0; e[7*COLS+3] = 1'b1;
        read_board(pb, vb);
        n_cmp++; if (pb !== e) begin n_fail++; $display("FAIL wr_set_board: got %h want %h", pb, e); end
        n_cmp++; if (vb !== e) begin n_fail++; $display("FAIL wr_set_vga: got %h want %h", vb, e); end
        wr(3, 7, 1'b0);
        read_board(pb, vb);
        n_cmp++; if (pb !== '0) begin n_fail++; $display("FAIL wr_clr_board: got %h want 0", pb); end
        wr(12, 5, 1'b1);
        wr(4, 25, 1'b1);
        read_board(pb, vb);
        n_cmp++; if (pb !== '0) begin n_fail++; $display("FAIL wr_oob_board: got %h want 0", pb); end
        n_cmp++; if (vb !== '0) begin n_fail++; $display("FAIL wr_oob_vga: got %h want 0", vb); end
    endtask

    task automatic test_empty_clear;
        int dc, bc; logic [4:0] lc; logic ba;
        run_clear(1'b0, dc, bc, lc, ba);
        n_cmp++; if (dc !== 21) begin n_fail++; $display("FAIL empty_done_cycle: got %0d want 21", dc); end
        n_cmp++; if (lc !== 5'd0) begin n_fail++; $display("FAIL empty_lines: got %0d want 0", lc); end
    endtask

    task automatic test_clear_one;
        logic [NC-1:0] pb, vb, e; int dc, bc; logic [4:0] lc; logic ba;
        do_reset();
        fill_row(19); wr(0, 18, 1'b1);
        run_clear(1'b0, dc, bc, lc, ba);
        n_cmp++; if (dc !== 22) begin n_fail++; $display("FAIL one_done_cycle: got %0d want 22", dc); end
        n_cmp++; if (bc !== 22) begin n_fail++; $display("FAIL one_busy_cycles: got %0d want 22", bc); end
        n_cmp++; if (ba !== 1'b0) begin n_fail++; $display("FAIL one_busy_after: got %b want 0", ba); end
        n_cmp++; if (lc !== 5'd1) begin n_fail++; $display("FAIL one_lines_at_done: got %0d want 1", lc); end
        n_cmp++; if (lines_cleared !== 5'd1) begin n_fail++; $display("FAIL one_lines_held: got %0d want 1", lines_cleared); end
        e = '0; e[19*COLS+0] = 1'b1;
        read_board(pb, vb);
        n_cmp++; if (pb !== e) begin n_fail++; $display("FAIL one_board: got %h want %h", pb, e); end
        n_cmp++; if (vb !== e) begin n_fail++; $display("FAIL one_vga: got %h want %h", vb, e); end
    endtask

    task automatic test_clear_four;
        logic [NC-1:0] pb, vb, e; int dc, bc; logic [4:0] lc; logic ba;
        do_reset();
        for (int y = 16; y < 20; y++) fill_row(y);
        wr(5, 15, 1'b1);
        run_clear(1'b0, dc, bc, lc, ba);
        n_cmp++; if (dc !== 25) begin n_fail++; $display("FAIL four_done_cycle: got %0d want 25", dc); end
        n_cmp++; if (lc !== 5'd4) begin n_fail++; $display("FAIL four_lines: got %0d want 4", lc); end
        e = '0; e[19*COLS+5] = 1'b1;
        read_board(pb, vb);
        n_cmp++; if (pb !== e) begin n_fail++; $display("FAIL four_board: got %h want %h", pb, e); end
    endtask

    task automatic test_clear_split;
        logic [NC-1:0] pb, vb, e; int dc, bc; logic [4:0] lc; logic ba;
        do_reset();
        fill_row(19); fill_row(17); wr(1, 18, 1'b1); wr(2, 16, 1'b1);
        run_clear(1'b0, dc, bc, lc, ba);
        n_cmp++; if (dc !== 23) begin n_fail++; $display("FAIL split_done_cycle: got %0d want 23", dc); end
        n_cmp++; if (lc !== 5'd2) begin n_fail++; $display("FAIL split_lines: got %0d want 2", lc); end
        e = '0; e[19*COLS+1] = 1'b1; e[18*COLS+2] = 1'b1;
        read_board(pb, vb);
        n_cmp++; if (pb !== e) begin n_fail++; $display("FAIL split_board: got %h want %h", pb, e); end
    endtask

    task automatic test_write_with_start;
        logic [NC-1:0] pb, vb; int dc, bc; logic [4:0] lc; logic ba;
        do_reset();
        for (int x = 0; x < COLS - 1; x++) wr(x, 19, 1'b1);
        board_we = 1'b1; board_wx = 4'd9; board_wy = 5'd19; board_wdata = 1'b1;
        run_clear(1'b0, dc, bc, lc, ba);
        n_cmp++; if (dc !== 22) begin n_fail++; $display("FAIL wstart_done_cycle: got %0d want 22", dc); end
        n_cmp++; if (lc !== 5'd1) begin n_fail++; $display("FAIL wstart_lines: got %0d want 1", lc); end
        read_board(pb, vb);
        n_cmp++; if (pb !== '0) begin n_fail++; $display("FAIL wstart_board: got %h want 0", pb); end
    endtask

    task automatic test_busy_ignore;
        logic [NC-1:0] pb, vb, e; int dc, bc; logic [4:0] lc; logic ba;
        do_reset();
        fill_row(19); wr(0, 18, 1'b1);
        run_clear(1'b1, dc, bc, lc, ba);
        n_cmp++; if (dc !== 22) begin n_fail++; $display("FAIL ignore_done_cycle: got %0d want 22", dc); end
        n_cmp++; if (ba !== 1'b0) begin n_fail++; $display("FAIL ignore_no_restart: got %b want 0", ba); end
        n_cmp++; if (lc !== 5'd1) begin n_fail++; $display("FAIL ignore_lines: got %0d want 1", lc); end
        e = '0; e[19*COLS+0] = 1'b1;
        read_board(pb, vb);
        n_cmp++; if (pb !== e) begin n_fail++; $display("FAIL ignore_board: got %h want %h", pb, e); end
    endtask

    task automatic test_reset_mid_clear;
        logic [NC-1:0] pb, vb; bit seen_done;
        do_reset();
        fill_row(19); wr(0, 18, 1'b1);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        n_cmp++; if (clear_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b want 1", clear_busy); end
        resetn = 1'b0;
        #1;
        n_cmp++; if (clear_busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_reset: got %b want 0", clear_busy); end
        read_board(pb, vb);
        n_cmp++; if (pb !== '0) begin n_fail++; $display("FAIL mid_board: got %h want 0", pb); end
        n_cmp++; if (lines_cleared !== 5'd0) begin n_fail++; $display("FAIL mid_lines: got %0d want 0", lines_cleared); end
        seen_done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c == 2) resetn = 1'b1;
            if (clear_done) seen_done = 1'b1;
            tick();
        end
        n_cmp++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL mid_no_done: got %b want 0", seen_done); end
    endtask

    initial begin
        resetn = 1'b0; board_we = 1'b0; board_wdata = 1'b0; clear_start = 1'b0;
        board_rx = '0; board_ry = '0; board_wx = '0; board_wy = '0; vga_rx = '0; vga_ry = '0;
        #12;
        resetn = 1'b1;
        tick();
        test_reset();
        test_write();
        test_empty_clear();
        test_clear_one();
        test_clear_four();
        test_clear_split();
        test_write_with_start();
        test_busy_ignore();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
